// File: rtl/perf_counter_bank.sv
// Bank of selectable event counters with sticky overflow, snapshot shadows
// and a registered shadow read port, plus a free-running enabled-cycle counter.
module perf_counter_bank #(
   parameter int NUM_CNT  = 4,
   parameter int CNT_W    = 32,
   parameter int NUM_EVT  = 8,
   parameter int SATURATE = 0,
   localparam int IW = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1,
   localparam int EW = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic [NUM_EVT-1:0] evt,
   input  logic               cfg_we,
   input  logic [IW-1:0]      cfg_idx,
   input  logic [EW-1:0]      cfg_sel,
   input  logic               cfg_edge,
   input  logic               cfg_on,
   input  logic [NUM_CNT-1:0] clr,
   input  logic               snap,
   input  logic [IW-1:0]      rd_idx,
   output logic [CNT_W-1:0]   rd_data,
   output logic [NUM_CNT-1:0] ovf,
   output logic [CNT_W-1:0]   cycles
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [CNT_W-1:0]   cnt_q     [NUM_CNT];
   logic [CNT_W-1:0]   cnt_d     [NUM_CNT];
   logic [CNT_W-1:0]   shadow_q  [NUM_CNT];
   logic [CNT_W-1:0]   shadow_d  [NUM_CNT];
   logic [EW-1:0]      sel_q     [NUM_CNT];
   logic [EW-1:0]      sel_d     [NUM_CNT];
   logic [NUM_EVT-1:0] src_s     [NUM_CNT];
   logic [NUM_EVT-1:0] match_s   [NUM_CNT];
   logic [NUM_CNT-1:0] ovf_q, ovf_d;
   logic [NUM_CNT-1:0] edge_q, edge_d;
   logic [NUM_CNT-1:0] on_q, on_d;
   logic [NUM_CNT-1:0] hit_s, inc_s;
   logic [NUM_EVT-1:0] evt_q, rise_s;
   logic [CNT_W-1:0]   rd_data_q, rd_data_d;
   logic [CNT_W-1:0]   cycles_q, cycles_d;

   // Event source selection: a select beyond NUM_EVT matches no input bit.
   always_comb begin
      rise_s = evt & ~evt_q;
      for (int i = 0; i < NUM_CNT; i++) begin
         src_s[i]   = edge_q[i] ? rise_s : evt;
         match_s[i] = {NUM_EVT{1'b0}};
         for (int e = 0; e < NUM_EVT; e++) begin
            match_s[i][e] = (sel_q[i] == e[EW-1:0]);
         end
         hit_s[i] = |(src_s[i] & match_s[i]);
      end
      inc_s = {NUM_CNT{en}} & on_q & hit_s;
   end

   // Counter and sticky overflow next state; clear wins over increment.
   always_comb begin
      for (int i = 0; i < NUM_CNT; i++) begin
         cnt_d[i] = cnt_q[i];
         ovf_d[i] = ovf_q[i];
         if (clr[i]) begin
            cnt_d[i] = CNT_ZERO;
            ovf_d[i] = 1'b0;
         end else if (inc_s[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               ovf_d[i] = 1'b1;
               cnt_d[i] = (SATURATE != 0) ? CNT_MAX : CNT_ZERO;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end else begin
            cnt_d[i] = cnt_q[i];
         end
      end
   end

   // Snapshot captures pre-update counter values; read mux returns 0 off the end.
   always_comb begin
      rd_data_d = CNT_ZERO;
      for (int i = 0; i < NUM_CNT; i++) begin
         shadow_d[i] = snap ? cnt_q[i] : shadow_q[i];
         rd_data_d   = rd_data_d | ({CNT_W{rd_idx == i[IW-1:0]}} & shadow_q[i]);
      end
   end

   // Config writes; an out-of-range index matches no counter.
   always_comb begin
      for (int i = 0; i < NUM_CNT; i++) begin
         sel_d[i]  = sel_q[i];
         edge_d[i] = edge_q[i];
         on_d[i]   = on_q[i];
         if (cfg_we && (cfg_idx == i[IW-1:0])) begin
            sel_d[i]  = cfg_sel;
            edge_d[i] = cfg_edge;
            on_d[i]   = cfg_on;
         end else begin
            on_d[i]   = on_q[i];
         end
      end
   end

   // Cycle counter wraps silently and has no overflow flag.
   always_comb begin
      cycles_d = en ? (cycles_q + CNT_ONE) : cycles_q;
   end

   // State registers with synchronous active-low reset overriding all updates.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            cnt_q[i]    <= CNT_ZERO;
            shadow_q[i] <= CNT_ZERO;
            sel_q[i]    <= {EW{1'b0}};
         end
         ovf_q     <= {NUM_CNT{1'b0}};
         edge_q    <= {NUM_CNT{1'b0}};
         on_q      <= {NUM_CNT{1'b0}};
         evt_q     <= {NUM_EVT{1'b0}};
         rd_data_q <= CNT_ZERO;
         cycles_q  <= CNT_ZERO;
      end else begin
         for (int i = 0; i < NUM_CNT; i++) begin
            cnt_q[i]    <= cnt_d[i];
            shadow_q[i] <= shadow_d[i];
            sel_q[i]    <= sel_d[i];
         end
         ovf_q     <= ovf_d;
         edge_q    <= edge_d;
         on_q      <= on_d;
         evt_q     <= evt;
         rd_data_q <= rd_data_d;
         cycles_q  <= cycles_d;
      end
   end

   assign rd_data = rd_data_q;
   assign ovf     = ovf_q;
   assign cycles  = cycles_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: a wrapping and a saturating 8-bit instance share
// stimulus; an abstract per-cycle model is compared every cycle, plus literal checks.
module tb_perf_counter_bank;

   localparam int NC   = 3;
   localparam int CW   = 8;
   localparam int NE   = 6;
   localparam int CMAX = 255;

   logic          clk = 1'b0;
   logic          reset, en, cfg_we, cfg_edge, cfg_on, snap;
   logic [NE-1:0] evt;
   logic [1:0]    cfg_idx, rd_idx;
   logic [2:0]    cfg_sel;
   logic [NC-1:0] clr;
   logic [CW-1:0] rd_w  [2];
   logic [NC-1:0] ovf_w [2];
   logic [CW-1:0] cyc_w [2];

   int  checks   = 0;
   int  failures = 0;
   bit  chk_on   = 1'b0;

   int          m_cnt [2][NC];
   int          m_ovf [2][NC];
   int          m_sh  [2][NC];
   int          m_rd  [2];
   int          m_cyc [2];
   int          c_sel [NC];
   int          c_edge[NC];
   int          c_on  [NC];
   logic [NE-1:0] evt_prev;

   always #5 clk = ~clk;

   perf_counter_bank #(.NUM_CNT(NC), .CNT_W(CW), .NUM_EVT(NE), .SATURATE(0)) u_wrap (
      .clk(clk), .reset(reset), .en(en), .evt(evt), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_sel(cfg_sel), .cfg_edge(cfg_edge), .cfg_on(cfg_on), .clr(clr), .snap(snap),
      .rd_idx(rd_idx), .rd_data(rd_w[0]), .ovf(ovf_w[0]), .cycles(cyc_w[0]));

   perf_counter_bank #(.NUM_CNT(NC), .CNT_W(CW), .NUM_EVT(NE), .SATURATE(1)) u_sat (
      .clk(clk), .reset(reset), .en(en), .evt(evt), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_sel(cfg_sel), .cfg_edge(cfg_edge), .cfg_on(cfg_on), .clr(clr), .snap(snap),
      .rd_idx(rd_idx), .rd_data(rd_w[1]), .ovf(ovf_w[1]), .cycles(cyc_w[1]));

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic bit model_inc(input int i);
      if (!en || c_on[i] == 0 || c_sel[i] >= NE) return 1'b0;
      if (c_edge[i] != 0) return evt[c_sel[i]] && !evt_prev[c_sel[i]];
      return evt[c_sel[i]];
   endfunction

   function automatic int ovf_exp(input int k);
      int v = 0;
      for (int i = 0; i < NC; i++) v = v | (m_ovf[k][i] << i);
      return v;
   endfunction

   // Behavioural model: instance 0 wraps, instance 1 saturates.
   always @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NC; i++) begin
               m_cnt[k][i] <= 0;
               m_ovf[k][i] <= 0;
               m_sh[k][i]  <= 0;
            end
            m_rd[k]  <= 0;
            m_cyc[k] <= 0;
         end
         for (int i = 0; i < NC; i++) begin
            c_sel[i]  <= 0;
            c_edge[i] <= 0;
            c_on[i]   <= 0;
         end
         evt_prev <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            m_rd[k]  <= (rd_idx < NC) ? m_sh[k][rd_idx] : 0;
            m_cyc[k] <= en ? (m_cyc[k] + 1) % 256 : m_cyc[k];
            for (int i = 0; i < NC; i++) begin
               if (snap) m_sh[k][i] <= m_cnt[k][i];
               if (clr[i]) begin
                  m_cnt[k][i] <= 0;
                  m_ovf[k][i] <= 0;
               end else if (model_inc(i)) begin
                  if (m_cnt[k][i] == CMAX) begin
                     m_ovf[k][i] <= 1;
                     m_cnt[k][i] <= (k == 1) ? CMAX : 0;
                  end else begin
                     m_cnt[k][i] <= m_cnt[k][i] + 1;
                  end
               end
            end
         end
         if (cfg_we && cfg_idx < NC) begin
            c_sel[cfg_idx]  <= cfg_sel;
            c_edge[cfg_idx] <= cfg_edge;
            c_on[cfg_idx]   <= cfg_on;
         end
         evt_prev <= evt;
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         for (int k = 0; k < 2; k++) begin
            check($sformatf("rd_data[%0d]", k), rd_w[k], m_rd[k]);
            check($sformatf("ovf[%0d]", k), ovf_w[k], ovf_exp(k));
            check($sformatf("cycles[%0d]", k), cyc_w[k], m_cyc[k]);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cfg(input int idx, input int sel, input int edg, input int on);
      cfg_we = 1'b1; cfg_idx = idx[1:0]; cfg_sel = sel[2:0];
      cfg_edge = edg[0]; cfg_on = on[0];
      cyc(1);
      cfg_we = 1'b0;
   endtask

   task automatic snap_read(input int idx, input int exp_w, input int exp_s, input string nm);
      rd_idx = idx[1:0]; snap = 1'b1;
      cyc(1);
      snap = 1'b0;
      cyc(1);
      check({nm, "_wrap"}, rd_w[0], exp_w);
      check({nm, "_sat"}, rd_w[1], exp_s);
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; evt = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0;
      cfg_edge = 1'b0; cfg_on = 1'b0; clr = '0; snap = 1'b0; rd_idx = '0;
      cyc(3);
      reset = 1'b1;
      check("reset_rd", rd_w[0], 0);
      check("reset_ovf", ovf_w[0], 0);
      check("reset_cycles", cyc_w[1], 0);
      chk_on = 1'b1;

      // Level counting of evt[3] for 10 cycles
      cfg(0, 3, 0, 1);
      en = 1'b1; evt = 6'b001000;
      cyc(10);
      evt = '0;
      snap_read(0, 10, 10, "level10");

      // Rising-edge counting on evt[2], then the same window with en low
      cfg(1, 2, 1, 1);
      for (int j = 0; j < 20; j++) begin
         evt = (j % 2 == 1) ? 6'b000100 : 6'b000000;
         cyc(1);
      end
      evt = '0;
      snap_read(1, 10, 10, "edge10");
      clr = 3'b010; cyc(1); clr = '0;
      en = 1'b0;
      for (int j = 0; j < 20; j++) begin
         evt = (j % 2 == 1) ? 6'b000100 : 6'b000000;
         cyc(1);
      end
      evt = '0;
      snap_read(1, 0, 0, "edge_en0");
      en = 1'b1;

      rd_idx = 2'd3; cyc(2);
      check("rd_oob", rd_w[0], 0);

      // Out-of-range event select never counts
      cfg(2, 7, 0, 1);
      evt = 6'h3F; cyc(5); evt = '0;
      snap_read(2, 0, 0, "sel_oob");

      // Overflow: wrap vs saturate, sticky flag, clear
      clr = 3'b001; cyc(1); clr = '0;
      evt = 6'b001000; cyc(255); evt = '0;
      snap_read(0, 255, 255, "at_max");
      check("ovf_pre_wrap", ovf_w[0][0], 0);
      evt = 6'b001000; cyc(1); evt = '0; cyc(1);
      check("ovf_set_wrap", ovf_w[0][0], 1);
      check("ovf_set_sat", ovf_w[1][0], 1);
      snap_read(0, 0, 255, "overflow");
      evt = 6'b001000; cyc(1); evt = '0; cyc(1);
      check("ovf_sticky_wrap", ovf_w[0][0], 1);
      snap_read(0, 1, 255, "post_ovf");
      clr = 3'b001; cyc(1); clr = '0; cyc(1);
      check("ovf_clr_wrap", ovf_w[0][0], 0);
      check("ovf_clr_sat", ovf_w[1][0], 0);
      snap_read(0, 0, 0, "cleared");

      // Snapshot and clear on the same cycle
      evt = 6'b001000; cyc(7); evt = '0;
      rd_idx = 2'd0; snap = 1'b1; clr = 3'b001;
      cyc(1);
      snap = 1'b0; clr = '0;
      cyc(1);
      check("snap_clr_old", rd_w[0], 7);
      snap_read(0, 0, 0, "snap_clr_new");

      // Select change during counting: write cycle uses the old event
      evt = 6'b001000; cyc(3);
      cfg(0, 4, 0, 1);
      cyc(3);
      evt = 6'b010000; cyc(2); evt = '0;
      snap_read(0, 6, 6, "cfg_switch");

      // Mid-count reset overrides snap, clr and cfg_we
      cfg(2, 5, 0, 1);
      evt = '0; cyc(1);
      evt = 6'h3F; cyc(3);
      reset = 1'b0; snap = 1'b1; clr = 3'b111;
      cfg_we = 1'b1; cfg_idx = 2'd0; cfg_sel = 3'd0; cfg_on = 1'b1;
      cyc(1);
      reset = 1'b1; snap = 1'b0; clr = '0; cfg_we = 1'b0; cfg_on = 1'b0;
      check("rst_rd", rd_w[0], 0);
      check("rst_ovf", ovf_w[1], 0);
      check("rst_cycles", cyc_w[0], 0);
      cyc(5);
      check("cycles_resume", cyc_w[0], 5);
      for (int i = 0; i < NC; i++) snap_read(i, 0, 0, $sformatf("rst_off%0d", i));
      evt = '0;
      cfg(0, 0, 0, 1);
      evt = 6'b000001; cyc(2); evt = '0;
      snap_read(0, 2, 2, "reconfig");

      cyc(2);
      chk_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 The module SHALL have parameter NUM_CNT, default 4, meaning the number of event counters (1..16).
REQ-002 The module SHALL have parameter CNT_W, default 32, meaning the counter and snapshot width in bits (8..64).
REQ-003 The module SHALL have parameter NUM_EVT, default 8, meaning the number of selectable event inputs (2..32).
REQ-004 The module SHALL have parameter SATURATE, default 0, meaning 0 = counters wrap on overflow and 1 = counters hold at all-ones.
REQ-005 The module SHALL use IW = max(1,$clog2(NUM_CNT)) and EW = max(1,$clog2(NUM_EVT)) as derived index widths.
REQ-006 The module SHALL have port clk, input, width 1, the single clock; all logic SHALL be clocked on its rising edge.
REQ-007 The module SHALL have port reset, input, width 1, a synchronous active-low reset.
REQ-008 The module SHALL have port en, input, width 1, the global count enable.
REQ-009 The module SHALL have port evt, input, width NUM_EVT, per-event level signals sampled every cycle.
REQ-010 The module SHALL have port cfg_we, input, width 1, the configuration write strobe.
REQ-011 The module SHALL have port cfg_idx, input, width IW, selecting the counter to configure.
REQ-012 The module SHALL have port cfg_sel, input, width EW, selecting the event source.
REQ-013 The module SHALL have port cfg_edge, input, width 1, where 0 = count cycles with the event high and 1 = count rising edges.
REQ-014 The module SHALL have port cfg_on, input, width 1, the per-counter enable value to be written.
REQ-015 The module SHALL have port clr, input, width NUM_CNT, per-counter clear.
REQ-016 The module SHALL have port snap, input, width 1, which copies all counters into the shadow registers.
REQ-017 The module SHALL have port rd_idx, input, width IW, the shadow read index.
REQ-018 The module SHALL have port rd_data, output, width CNT_W, the registered shadow value.
REQ-019 The module SHALL have port ovf, output, width NUM_CNT, sticky per-counter overflow flags.
REQ-020 The module SHALL have port cycles, output, width CNT_W, a free-running cycle count gated by en.

Function
REQ-021 Each counter i SHALL hold the config state sel_i, edge_i and on_i, written on a cfg_we cycle only when cfg_idx < NUM_CNT; an out-of-range cfg_idx SHALL be ignored.
REQ-022 A config write SHALL take effect from the next cycle and SHALL NOT change the counter value or ovf_i; the write cycle SHALL count under the old config.
REQ-023 The module SHALL register evt every cycle, independent of en, into evt_q (reset value 0); rise = evt & ~evt_q.
REQ-024 The increment condition inc_i SHALL be en & on_i & (edge_i ? rise[sel_i] : evt[sel_i]); an out-of-range sel_i SHALL never increment.
REQ-025 When inc_i is high, counter i SHALL increment by exactly 1 per cycle, with the update visible on the next cycle.
REQ-026 When SATURATE=0 and the counter is all-ones with inc_i high, the counter SHALL wrap to 0 and ovf_i SHALL set.
REQ-027 When SATURATE=1 and the counter is all-ones with inc_i high, the counter SHALL hold all-ones and ovf_i SHALL set.
REQ-028 ovf_i SHALL remain set until clr[i] or reset.
REQ-029 clr[i] SHALL take priority over inc_i, zeroing counter i and ovf_i on the next cycle; config state SHALL be unaffected by clr.
REQ-030 On a snap cycle, every shadow_i SHALL capture the counter register value present at that edge (pre-increment, pre-clear).
REQ-031 When snap and clr[i] coincide, shadow_i SHALL capture the old value and the counter SHALL clear.
REQ-032 rd_data SHALL equal shadow[rd_idx] registered with 1-cycle latency, reading 0 when rd_idx >= NUM_CNT.
REQ-033 When snap at cycle t and rd_idx is held, rd_data SHALL show the new shadow value at t+2.
REQ-034 cycles SHALL increment by 1 each cycle en is high, SHALL wrap silently regardless of SATURATE, and SHALL have no overflow flag.
REQ-035 Counter updates, clears and snapshots for all counters SHALL occur in the same cycle with no arbitration stalls.

Reset
REQ-036 While reset=0 at a rising edge, all counters, shadows, ovf, cycles, rd_data and evt_q SHALL be 0, and every config SHALL be sel=0, edge=0, on=0.
REQ-037 Reset asserted mid-count SHALL override clr, snap and cfg_we in that cycle, and counting SHALL resume only from the first edge after reset=1.

Verification
REQ-038 The bench SHALL cover: cfg counter0 sel=3 edge=0 on=1, en=1, evt[3] high 10 cycles -> snap, rd_idx=0 -> rd_data=10 at snap+2.
REQ-039 The bench SHALL cover: counter1 edge=1 on evt[2], evt[2] toggling 0/1 for 20 cycles -> counter1=10, and en=0 for the whole window -> 0.
REQ-040 The bench SHALL cover: CNT_W=8, SATURATE=0, counter at 255 plus 1 event -> 0 with ovf[0]=1; SATURATE=1 -> holds 255 with ovf[0]=1; clr[0] -> 0 with ovf[0]=0.
REQ-041 The bench SHALL cover: snap with clr[0] on the same cycle with counter0=7 -> rd_data=7 and counter0=0 next cycle.
REQ-042 The bench SHALL cover: cfg_we changing sel during active counting -> the write cycle counts the old event and the next cycle counts the new one.
REQ-043 The bench SHALL cover: reset=0 for one cycle mid-count with all counters nonzero -> all outputs 0 and all on=0, so no counting until reconfigured.
